inst_fetcher: RTL

- Front-end fetch stage directly upstream of the decoder.
- Holds the fetch PC and issues word requests to the memory controller.
- Buffers returned instructions in a small FIFO and presents the head to the decoder as DecEn/inst/instPC.
- Sequential PC+4 fetch only; redirects to jumpAddr on mistaken, flushing the queue and discarding any in-flight response.

---
 rtl/inst_fetcher_pkg.sv | 34 +++
 rtl/inst_fetcher_if.sv | 33 +++
 rtl/inst_queue.sv | 75 +++++++
 rtl/inst_fetcher.sv | 121 ++++++++++++
 4 files changed

// File: rtl/inst_fetcher_pkg.sv
// Shared types for the instruction fetch front end: bus widths, the fetch
// FSM encoding, the queue entry layout and the sequential PC step.
package inst_fetcher_pkg;

   localparam int INST_ADDR_W = 32;
   localparam int INST_W      = 32;

   typedef logic [INST_ADDR_W-1:0] inst_addr_t;
   typedef logic [INST_W-1:0]      inst_t;

   localparam inst_addr_t DEFAULT_RESET_PC = 32'h0000_0000;
   localparam inst_addr_t INST_STRIDE      = 32'd4;

   // IDLE: nothing outstanding.
   // WAIT: request outstanding and its word is wanted.
   // DROP: request outstanding but its word belongs to a squashed path.
   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_DROP = 2'd2
   } fetch_state_e;

   // One buffered instruction together with the address it was fetched from.
   typedef struct packed {
      inst_t      inst;
      inst_addr_t pc;
   } queue_entry_t;

   // Sequential successor of a fetch address; wraps at 32 bits.
   function automatic inst_addr_t next_pc(input inst_addr_t addr);
      return addr + INST_STRIDE;
   endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Bundle of the fetch stage's control, memory and decoder signals.
// master = the fetch stage, slave = the surrounding pipeline/memory.
interface inst_fetcher_if;
   import inst_fetcher_pkg::*;

   // pipeline control
   logic       rdy;
   logic       stall;
   logic       mistaken;
   inst_addr_t jumpAddr;

   // memory controller handshake
   logic       fetchReq;
   inst_addr_t fetchAddr;
   logic       memDone;
   inst_t      memData;

   // decoder side
   logic       DecEn;
   inst_t      inst;
   inst_addr_t instPC;

   modport master (
      input  rdy, stall, mistaken, jumpAddr, memDone, memData,
      output fetchReq, fetchAddr, DecEn, inst, instPC
   );

   modport slave (
      output rdy, stall, mistaken, jumpAddr, memDone, memData,
      input  fetchReq, fetchAddr, DecEn, inst, instPC
   );

endinterface

// File: rtl/inst_queue.sv
// Small synchronous FIFO of fetched instructions. The head entry is read
// combinationally so the decoder sees it in the same cycle it becomes valid.
// Flush wins over push/pop; nothing moves while en_i is low.
module inst_queue
   import inst_fetcher_pkg::*;
#(
   parameter int  DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = PTR_W + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   input  logic               flush_i,
   input  logic               push_i,
   input  logic               pop_i,
   input  queue_entry_t       push_data_i,
   output queue_entry_t       head_o,
   output logic [CNT_W-1:0]   count_o
);

   queue_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wr_en;

   // Next pointers/occupancy; DEPTH is a power of two so pointers wrap freely.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      wr_en   = 1'b0;
      if (en_i) begin
         if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end else begin
            wr_en = push_i;
            if (push_i) begin
               tail_d = tail_q + PTR_W'(1);
            end
            if (pop_i) begin
               head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
         end
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem_q[tail_q] <= push_data_i;
      end
   end

   assign head_o  = mem_q[head_q];
   assign count_o = count_q;

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: walks the PC forward in 4-byte steps, keeps at most one word
// request outstanding to memory, and buffers returned words for the decoder.
// A mispredict redirects the PC and flushes the buffer; a request already in
// flight still has to finish its handshake, so its word is dropped on return.
module inst_fetcher
   import inst_fetcher_pkg::*;
#(
   parameter int         QUEUE_DEPTH = 2,
   parameter inst_addr_t RESET_PC    = DEFAULT_RESET_PC
) (
   input logic            clk,
   input logic            rst,
   inst_fetcher_if.master fe_if
);

   localparam int CNT_W = ((QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

   fetch_state_e     state_q, state_d;
   inst_addr_t       pc_q, pc_d;
   inst_addr_t       req_addr_q, req_addr_d;

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_after_pop;
   logic [CNT_W-1:0] count_after_rsp;
   queue_entry_t     head;
   queue_entry_t     push_entry;
   logic             dec_en;
   logic             pop;
   logic             push;

   // A mispredict hides the head in the same cycle so nothing stale decodes.
   assign dec_en = (count != '0) & ~fe_if.mistaken;
   assign pop    = dec_en & ~fe_if.stall;

   // Occupancy seen by the issue decision: the outstanding request is counted
   // against free space so a returning word always has a slot.
   assign count_after_pop = count - CNT_W'(pop);
   assign count_after_rsp = count_after_pop + CNT_W'(1);

   assign push       = (state_q == FETCH_WAIT) & fe_if.memDone & ~fe_if.mistaken;
   assign push_entry = '{inst: fe_if.memData, pc: req_addr_q};

   inst_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .en_i        (fe_if.rdy),
      .flush_i     (fe_if.mistaken),
      .push_i      (push),
      .pop_i       (pop),
      .push_data_i (push_entry),
      .head_o      (head),
      .count_o     (count)
   );

   // Fetch FSM next-state, PC and request address.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      if (fe_if.rdy) begin
         if (fe_if.mistaken) begin
            pc_d = fe_if.jumpAddr;
            case (state_q)
               FETCH_WAIT: state_d = fe_if.memDone ? FETCH_IDLE : FETCH_DROP;
               // the old handshake may still complete on this very edge
               FETCH_DROP: if (fe_if.memDone) state_d = FETCH_IDLE;
               default:    state_d = state_q;
            endcase
         end else begin
            case (state_q)
               FETCH_IDLE: begin
                  if (count_after_pop < DEPTH_C) begin
                     req_addr_d = pc_q;
                     state_d    = FETCH_WAIT;
                  end
               end
               FETCH_WAIT: begin
                  if (fe_if.memDone) begin
                     pc_d = next_pc(req_addr_q);
                     // back-to-back: chain the next word while a slot remains
                     if (count_after_rsp < DEPTH_C) begin
                        req_addr_d = next_pc(req_addr_q);
                     end else begin
                        state_d = FETCH_IDLE;
                     end
                  end
               end
               FETCH_DROP: begin
                  if (fe_if.memDone) begin
                     state_d = FETCH_IDLE;
                  end
               end
               default: state_d = FETCH_IDLE;
            endcase
         end
      end
   end

   // State, PC and request address registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FETCH_IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
      end
   end

   assign fe_if.fetchReq  = (state_q != FETCH_IDLE);
   assign fe_if.fetchAddr = req_addr_q;
   assign fe_if.DecEn     = dec_en;
   assign fe_if.inst      = head.inst;
   assign fe_if.instPC    = head.pc;

endmodule
